// File: rtl/mips_cpu_muldiv.sv
// Iterative multiply/divide unit holding the MIPS HI/LO pair.
// Optional single-cycle multiplier: define MIPS_CPU_MULDIV_FAST_MULT_EN.
module mips_cpu_muldiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state, state_next;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] rem;
    logic [31:0] dvs;
    logic        is_div, neg_res, neg_rem;

    logic        accept, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum, div_shift;
    logic        div_ge;
    logic [63:0] product;
    logic [31:0] quot, rmd;

    assign accept = (state == IDLE) && start && !op[2];
    assign a_neg  = !op[0] && a[31];
    assign b_neg  = !op[0] && b[31];
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;

    // Multiply: acc[63:32] accumulates while the multiplier shifts out of acc[31:0].
    // Divide: dividend bits shift out of acc[31] as quotient bits shift in.
    assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, dvs} : 33'd0);
    assign div_shift = {rem, acc[31]};
    assign div_ge    = div_shift >= {1'b0, dvs};

    assign product = neg_res ? -acc : acc;
    assign quot    = neg_res ? -acc[31:0] : acc[31:0];
    assign rmd     = neg_rem ? -rem : rem;

    assign busy = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
                    state_next = op[1] ? CALC : FIX;
`else
                    state_next = CALC;
`endif
                end
            end
            CALC:    if (cnt == 5'd31) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            rem     <= '0;
            dvs     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt     <= '0;
                        rem     <= '0;
                        dvs     <= b_mag;
                        is_div  <= op[1];
                        // A zero divisor yields an all-ones quotient magnitude; keep it unsigned.
                        neg_res <= (a_neg ^ b_neg) && !(op[1] && (b == 32'd0));
                        neg_rem <= a_neg;
`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
                        acc     <= op[1] ? {32'd0, a_mag} : ({32'd0, a_mag} * {32'd0, b_mag});
`else
                        acc     <= {32'd0, a_mag};
`endif
                    end else if (start && (op == 3'd4)) begin
                        hi <= a;
                    end else if (start && (op == 3'd5)) begin
                        lo <= a;
                    end
                end
                CALC: begin
                    cnt <= cnt + 5'd1;
                    if (is_div) begin
                        rem        <= div_ge ? 32'(div_shift - {1'b0, dvs}) : div_shift[31:0];
                        acc[31:0]  <= {acc[30:0], div_ge};
                    end else begin
                        acc <= {mul_sum, acc[31:1]};
                    end
                end
                FIX: begin
                    done <= 1'b1;
                    if (is_div) begin
                        lo <= quot;
                        hi <= rmd;
                    end else begin
                        lo <= product[31:0];
                        hi <= product[63:32];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Self-checking bench for mips_cpu_muldiv: directed cases plus random ops vs an arithmetic model.
module tb_mips_cpu_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    mips_cpu_muldiv dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic void model_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      ps;
        logic [63:0] pu;
        int          q, r;
        case (o)
            3'd0: begin
                ps = longint'($signed(x)) * longint'($signed(y));
                {m_hi, m_lo} = ps;
            end
            3'd1: begin
                pu = 64'(x) * 64'(y);
                {m_hi, m_lo} = pu;
            end
            3'd2: begin
                if (y == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = x;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000; m_hi = 32'd0;
                end else begin
                    q = $signed(x) / $signed(y);
                    r = $signed(x) % $signed(y);
                    m_lo = q; m_hi = r;
                end
            end
            3'd3: begin
                if (y == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = x;
                end else begin
                    m_lo = x / y; m_hi = x % y;
                end
            end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: ;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit interfere, input string tag);
        int          lat_exp;
        int          n;
        logic [31:0] old_hi, old_lo;
        lat_exp = (FAST && o < 3'd2) ? 1 : 33;
        old_hi  = m_hi;
        old_lo  = m_lo;
        model_op(o, x, y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        if (interfere) begin
            op = 3'd5; a = 32'hDEAD_BEEF;
        end else begin
            start = 1'b0; a = $urandom; b = $urandom;
        end
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_done_low"}, done, 1'b0);
        check({tag, "_hold"}, {hi, lo}, {old_hi, old_lo});
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            if (n == lat_exp - 1) check({tag, "_hold_late"}, {hi, lo}, {old_hi, old_lo});
            if (done) break;
        end
        check({tag, "_latency"}, n, lat_exp);
        check({tag, "_busy_end"}, busy, 1'b0);
        check({tag, "_hi"}, hi, m_hi);
        check({tag, "_lo"}, lo, m_lo);
    endtask

    task automatic run_mt(input logic [2:0] o, input logic [31:0] x, input string tag);
        model_op(o, x, 32'd0);
        @(negedge clk);
        start = 1'b1; op = o; a = x;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_hi"}, hi, m_hi);
        check({tag, "_lo"}, lo, m_lo);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #12;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, "mult_neg");
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg");
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        run_op(3'd3, 32'd100, 32'd0, 1'b0, "divu_zero");
        run_op(3'd2, 32'hFFFF_FF9C, 32'd0, 1'b0, "div_zero_neg");
        run_mt(3'd4, 32'h1234_5678, "mthi");
        run_mt(3'd5, 32'hCAFE_F00D, "mtlo");
        run_mt(3'd6, 32'h5555_5555, "op6");
        run_mt(3'd7, 32'hAAAA_AAAA, "op7");
        run_op(3'd1, 32'h0001_0003, 32'h0002_0005, 1'b1, "multu_mtlo_ignored");

        // Abort a divide mid-flight with an asynchronous reset.
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_hilo", {hi, lo}, 64'd0);
        m_hi = '0; m_lo = '0;
        repeat (3) @(posedge clk);
        #1 check("abort_no_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd3, 32'd1000, 32'd3, 1'b0, "divu_after_reset");

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 3)), pick_operand(), pick_operand(), 1'b0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
